// File: rtl/cpu_opcodes_pkg.sv
// Opcode constants shared by the control unit and the front-end sequencer,
// plus the sequence-kind encoding and small decode helpers.
package cpu_opcodes_pkg;

    localparam int OP_W   = 6;
    localparam int KIND_W = 3;

    localparam logic [OP_W-1:0] OP_NOP     = 6'b001_000;
    localparam logic [OP_W-1:0] OP_CALL    = 6'b011_100;
    localparam logic [OP_W-1:0] OP_LDM     = 6'b010_010;
    localparam logic [OP_W-1:0] OP_SHL     = 6'b000_101;
    localparam logic [OP_W-1:0] OP_SHR     = 6'b000_110;
    localparam logic [OP_W-1:0] OP_POPF    = 6'b011_101;
    localparam logic [OP_W-1:0] OP_POPPCH  = 6'b011_111;
    localparam logic [OP_W-1:0] OP_POPPCL  = 6'b011_110;
    localparam logic [OP_W-1:0] OP_PUSHPCH = 6'b111_010;
    localparam logic [OP_W-1:0] OP_PUSHPCL = 6'b111_011;
    localparam logic [OP_W-1:0] OP_RET     = 6'b100_000;
    localparam logic [OP_W-1:0] OP_RTI     = 6'b100_001;
    localparam logic [OP_W-1:0] OP_PUSHF   = 6'b111_100;
    localparam logic [OP_W-1:0] OP_INTJ    = 6'b111_101;

    typedef enum logic [KIND_W-1:0] {
        SEQ_NONE = 3'd0,
        SEQ_CALL = 3'd1,
        SEQ_RET  = 3'd2,
        SEQ_RTI  = 3'd3,
        SEQ_INT  = 3'd4
    } seq_kind_e;

    // Words that are followed by a raw immediate in the instruction stream.
    function automatic logic is_imm_prefix(input logic [OP_W-1:0] op);
        return (op == OP_LDM) || (op == OP_SHL) || (op == OP_SHR);
    endfunction

    function automatic logic seq_legal(input logic [KIND_W-1:0] kind, input logic [1:0] step);
        logic ok;
        case (kind)
            SEQ_NONE:          ok = (step == 2'd0);
            SEQ_CALL, SEQ_RET: ok = (step != 2'd3);
            SEQ_RTI, SEQ_INT:  ok = 1'b1;
            default:           ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ctl_seq_rom.sv
// Micro-op table: maps (sequence kind, step index) to the opcode emitted in
// that step and whether it is the final step of the sequence.
module ctl_seq_rom
    import cpu_opcodes_pkg::*;
(
    input  logic [KIND_W-1:0] kind,
    input  logic [1:0]        step,
    output logic [OP_W-1:0]   opcode,
    output logic              last
);

    // Table lookup; anything outside a defined sequence reads as NOP.
    always_comb begin
        opcode = OP_NOP;
        last   = 1'b0;
        case (kind)
            SEQ_CALL: begin
                case (step)
                    2'd0:    opcode = OP_PUSHPCH;
                    2'd1:    opcode = OP_PUSHPCL;
                    2'd2:    begin opcode = OP_CALL; last = 1'b1; end
                    default: begin opcode = OP_NOP; last = 1'b0; end
                endcase
            end
            SEQ_RET: begin
                case (step)
                    2'd0:    opcode = OP_POPPCH;
                    2'd1:    opcode = OP_POPPCL;
                    2'd2:    begin opcode = OP_NOP; last = 1'b1; end
                    default: begin opcode = OP_NOP; last = 1'b0; end
                endcase
            end
            SEQ_RTI: begin
                case (step)
                    2'd0:    opcode = OP_POPPCH;
                    2'd1:    opcode = OP_POPPCL;
                    2'd2:    opcode = OP_POPF;
                    2'd3:    begin opcode = OP_NOP; last = 1'b1; end
                    default: begin opcode = OP_NOP; last = 1'b0; end
                endcase
            end
            SEQ_INT: begin
                case (step)
                    2'd0:    opcode = OP_PUSHPCH;
                    2'd1:    opcode = OP_PUSHPCL;
                    2'd2:    opcode = OP_PUSHF;
                    2'd3:    begin opcode = OP_INTJ; last = 1'b1; end
                    default: begin opcode = OP_NOP; last = 1'b0; end
                endcase
            end
            default: begin
                opcode = OP_NOP;
                last   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ctl_sequencer.sv
// Front-end sequencer: passes fetched words through to the control unit and
// expands CALL/RET/RTI and interrupts into stack micro-op sequences.
module ctl_sequencer
    import cpu_opcodes_pkg::*;
#(
    parameter int OPW = OP_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] in_opcode,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           stall_ld,
    input  logic           int_req,
    output logic [OPW-1:0] op_out,
    output logic           op_valid,
    output logic           int_ack,
    output logic           seq_busy
);

    seq_kind_e      kind_q, kind_d;
    logic [1:0]     step_q, step_d;
    logic           imm_pending_q, imm_pending_d;
    logic           int_pending_q, int_pending_d;
    logic [OPW-1:0] op_out_q, op_out_d;
    logic           op_valid_q, op_valid_d;
    logic           int_ack_q, int_ack_d;

    logic           cur_last;
    logic [OPW-1:0] cur_op_unused;
    logic [OPW-1:0] nxt_op;
    logic           nxt_last_unused;
    logic           legal, boundary, take_int, accept, pass;

    // Current step tells us whether the opcode slot frees up this cycle.
    ctl_seq_rom u_rom_cur (
        .kind   (kind_q),
        .step   (step_q),
        .opcode (cur_op_unused),
        .last   (cur_last)
    );

    // Next step supplies the micro-op that gets registered onto op_out.
    ctl_seq_rom u_rom_nxt (
        .kind   (kind_d),
        .step   (step_d),
        .opcode (nxt_op),
        .last   (nxt_last_unused)
    );

    // Handshake, interrupt take and next sequence position.
    always_comb begin
        legal    = seq_legal(kind_q, step_q);
        boundary = legal && ((kind_q == SEQ_NONE) || cur_last);
        take_int = int_pending_q && !imm_pending_q && !stall_ld && boundary;
        in_ready = !rst && !stall_ld && boundary && !take_int;
        accept   = in_valid && in_ready;

        kind_d        = kind_q;
        step_d        = step_q;
        imm_pending_d = imm_pending_q;
        int_pending_d = int_pending_q || int_req;
        int_ack_d     = 1'b0;
        pass          = 1'b0;

        if (stall_ld) begin
            pass = 1'b0;
        end else if (!legal) begin
            kind_d = SEQ_NONE;
            step_d = 2'd0;
        end else if (take_int) begin
            // The request level seen in the take cycle is already being served.
            kind_d        = SEQ_INT;
            step_d        = 2'd0;
            int_pending_d = 1'b0;
            int_ack_d     = 1'b1;
        end else if (boundary) begin
            kind_d = SEQ_NONE;
            step_d = 2'd0;
            if (accept) begin
                imm_pending_d = !imm_pending_q && is_imm_prefix(in_opcode);
                if (imm_pending_q) begin
                    pass = 1'b1;
                end else begin
                    case (in_opcode)
                        OP_CALL: kind_d = SEQ_CALL;
                        OP_RET:  kind_d = SEQ_RET;
                        OP_RTI:  kind_d = SEQ_RTI;
                        default: pass   = 1'b1;
                    endcase
                end
            end else begin
                pass = 1'b0;
            end
        end else begin
            step_d = step_q + 2'd1;
        end
    end

    // Output slot selection: hold on stall, else micro-op, pass-through or NOP.
    always_comb begin
        op_out_d   = op_out_q;
        op_valid_d = op_valid_q;
        if (stall_ld) begin
            op_out_d   = op_out_q;
            op_valid_d = op_valid_q;
        end else if (kind_d != SEQ_NONE) begin
            op_out_d   = nxt_op;
            op_valid_d = 1'b1;
        end else if (pass) begin
            op_out_d   = in_opcode;
            op_valid_d = 1'b1;
        end else begin
            op_out_d   = OP_NOP;
            op_valid_d = 1'b0;
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kind_q        <= SEQ_NONE;
            step_q        <= 2'd0;
            imm_pending_q <= 1'b0;
            int_pending_q <= 1'b0;
            op_out_q      <= OP_NOP;
            op_valid_q    <= 1'b0;
            int_ack_q     <= 1'b0;
        end else begin
            kind_q        <= kind_d;
            step_q        <= step_d;
            imm_pending_q <= imm_pending_d;
            int_pending_q <= int_pending_d;
            op_out_q      <= op_out_d;
            op_valid_q    <= op_valid_d;
            int_ack_q     <= int_ack_d;
        end
    end

    assign op_out   = op_out_q;
    assign op_valid = op_valid_q;
    assign int_ack  = int_ack_q;
    assign seq_busy = (kind_q != SEQ_NONE);

endmodule

// File: tb/tb_ctl_sequencer.sv
// Table-driven bench for ctl_sequencer: per-cycle stimulus records with the
// expected handshake and the outputs that must follow the next clock edge.
module tb_ctl_sequencer;

    localparam logic [5:0] NOP  = 6'b001_000;
    localparam logic [5:0] ADD  = 6'b000_001;
    localparam logic [5:0] SUB  = 6'b000_010;
    localparam logic [5:0] CALL = 6'b011_100;
    localparam logic [5:0] RET  = 6'b100_000;
    localparam logic [5:0] RTI  = 6'b100_001;
    localparam logic [5:0] LDM  = 6'b010_010;
    localparam logic [5:0] SHL  = 6'b000_101;
    localparam logic [5:0] SHR  = 6'b000_110;
    localparam logic [5:0] PCH  = 6'b111_010;
    localparam logic [5:0] PCL  = 6'b111_011;
    localparam logic [5:0] PSHF = 6'b111_100;
    localparam logic [5:0] INTJ = 6'b111_101;
    localparam logic [5:0] PPH  = 6'b011_111;
    localparam logic [5:0] PPL  = 6'b011_110;
    localparam logic [5:0] POPF = 6'b011_101;
    localparam logic [5:0] IMM  = 6'h2A;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] in_opcode;
    logic       in_valid, in_ready, stall_ld, int_req;
    logic [5:0] op_out;
    logic       op_valid, int_ack, seq_busy;

    always #5 clk = ~clk;

    ctl_sequencer #(.OPW(6)) dut (
        .clk(clk), .rst(rst), .in_opcode(in_opcode), .in_valid(in_valid),
        .in_ready(in_ready), .stall_ld(stall_ld), .int_req(int_req),
        .op_out(op_out), .op_valid(op_valid), .int_ack(int_ack), .seq_busy(seq_busy)
    );

    typedef struct {
        logic [5:0] op;
        logic       vld, stall, irq, rdy;
        logic [5:0] eop;
        logic       evld, eack, ebusy;
    } vec_t;

    typedef struct {
        logic [5:0] op;
        logic       vld, ack, busy;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(input logic [5:0] op, input logic vld, input logic stall,
                                input logic irq, input logic rdy, input logic [5:0] eop,
                                input logic evld, input logic eack, input logic ebusy);
        vec_t v;
        v.op = op; v.vld = vld; v.stall = stall; v.irq = irq; v.rdy = rdy;
        v.eop = eop; v.evld = evld; v.eack = eack; v.ebusy = ebusy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        @(negedge clk);
        in_opcode = v.op; in_valid = v.vld; stall_ld = v.stall; int_req = v.irq;
        #1;
        chk({tag, " in_ready"}, {5'd0, in_ready}, {5'd0, v.rdy});
        sb.push_back('{v.eop, v.evld, v.eack, v.ebusy});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, " op_out"},   op_out,              e.op);
        chk({tag, " op_valid"}, {5'd0, op_valid},    {5'd0, e.vld});
        chk({tag, " int_ack"},  {5'd0, int_ack},     {5'd0, e.ack});
        chk({tag, " seq_busy"}, {5'd0, seq_busy},    {5'd0, e.busy});
    endtask

    initial begin
        rst = 1'b1; in_opcode = 6'd0; in_valid = 1'b0; stall_ld = 1'b0; int_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset op_out",   op_out,              NOP);
        chk("reset op_valid", {5'd0, op_valid},    6'd0);
        chk("reset int_ack",  {5'd0, int_ack},     6'd0);
        chk("reset seq_busy", {5'd0, seq_busy},    6'd0);
        chk("reset in_ready", {5'd0, in_ready},    6'd0);
        @(negedge clk);
        rst = 1'b0;

        // Pass-through, stall freeze, immediates never decoded
        vecs.push_back(mk(ADD,  1, 0, 0, 1, ADD,  1, 0, 0));
        vecs.push_back(mk(SUB,  1, 1, 0, 0, ADD,  1, 0, 0));
        vecs.push_back(mk(SUB,  1, 0, 0, 1, SUB,  1, 0, 0));
        vecs.push_back(mk(LDM,  1, 0, 0, 1, LDM,  1, 0, 0));
        vecs.push_back(mk(CALL, 1, 0, 0, 1, CALL, 1, 0, 0));
        vecs.push_back(mk(SHL,  1, 0, 0, 1, SHL,  1, 0, 0));
        vecs.push_back(mk(RET,  1, 0, 0, 1, RET,  1, 0, 0));
        vecs.push_back(mk(SHR,  1, 0, 0, 1, SHR,  1, 0, 0));
        vecs.push_back(mk(LDM,  1, 0, 0, 1, LDM,  1, 0, 0));
        vecs.push_back(mk(CALL, 1, 0, 0, 1, PCH,  1, 0, 1));
        vecs.push_back(mk(NOP,  0, 0, 0, 0, PCL,  1, 0, 1));
        vecs.push_back(mk(NOP,  0, 0, 0, 0, CALL, 1, 0, 1));
        vecs.push_back(mk(NOP,  0, 0, 0, 1, NOP,  0, 0, 0));
        // CALL then ADD
        vecs.push_back(mk(CALL, 1, 0, 0, 1, PCH,  1, 0, 1));
        vecs.push_back(mk(ADD,  1, 0, 0, 0, PCL,  1, 0, 1));
        vecs.push_back(mk(ADD,  1, 0, 0, 0, CALL, 1, 0, 1));
        vecs.push_back(mk(ADD,  1, 0, 0, 1, ADD,  1, 0, 0));
        vecs.push_back(mk(NOP,  0, 0, 0, 1, NOP,  0, 0, 0));
        // Back-to-back CALLs
        vecs.push_back(mk(CALL, 1, 0, 0, 1, PCH,  1, 0, 1));
        vecs.push_back(mk(CALL, 1, 0, 0, 0, PCL,  1, 0, 1));
        vecs.push_back(mk(CALL, 1, 0, 0, 0, CALL, 1, 0, 1));
        vecs.push_back(mk(CALL, 1, 0, 0, 1, PCH,  1, 0, 1));
        vecs.push_back(mk(NOP,  0, 0, 0, 0, PCL,  1, 0, 1));
        vecs.push_back(mk(NOP,  0, 0, 0, 0, CALL, 1, 0, 1));
        vecs.push_back(mk(NOP,  0, 0, 0, 1, NOP,  0, 0, 0));
        // RET
        vecs.push_back(mk(RET,  1, 0, 0, 1, PPH,  1, 0, 1));
        vecs.push_back(mk(NOP,  0, 0, 0, 0, PPL,  1, 0, 1));
        vecs.push_back(mk(NOP,  0, 0, 0, 0, NOP,  1, 0, 1));
        vecs.push_back(mk(NOP,  0, 0, 0, 1, NOP,  0, 0, 0));
        // RTI with a two-cycle stall in the second step
        vecs.push_back(mk(RTI,  1, 0, 0, 1, PPH,  1, 0, 1));
        vecs.push_back(mk(NOP,  0, 0, 0, 0, PPL,  1, 0, 1));
        vecs.push_back(mk(NOP,  0, 1, 0, 0, PPL,  1, 0, 1));
        vecs.push_back(mk(NOP,  0, 1, 0, 0, PPL,  1, 0, 1));
        vecs.push_back(mk(NOP,  0, 0, 0, 0, POPF, 1, 0, 1));
        vecs.push_back(mk(NOP,  0, 0, 0, 0, NOP,  1, 0, 1));
        vecs.push_back(mk(NOP,  0, 0, 0, 1, NOP,  0, 0, 0));
        // Interrupt deferred by an immediate
        vecs.push_back(mk(LDM,  1, 0, 0, 1, LDM,  1, 0, 0));
        vecs.push_back(mk(IMM,  1, 0, 1, 1, IMM,  1, 0, 0));
        vecs.push_back(mk(ADD,  1, 0, 0, 0, PCH,  1, 1, 1));
        vecs.push_back(mk(ADD,  1, 0, 0, 0, PCL,  1, 0, 1));
        vecs.push_back(mk(ADD,  1, 0, 0, 0, PSHF, 1, 0, 1));
        vecs.push_back(mk(ADD,  1, 0, 0, 0, INTJ, 1, 0, 1));
        vecs.push_back(mk(ADD,  1, 0, 0, 1, ADD,  1, 0, 0));
        vecs.push_back(mk(NOP,  0, 0, 0, 1, NOP,  0, 0, 0));
        // Interrupt raised during CALL2
        vecs.push_back(mk(CALL, 1, 0, 0, 1, PCH,  1, 0, 1));
        vecs.push_back(mk(SUB,  1, 0, 0, 0, PCL,  1, 0, 1));
        vecs.push_back(mk(SUB,  1, 0, 1, 0, CALL, 1, 0, 1));
        vecs.push_back(mk(SUB,  1, 0, 0, 0, PCH,  1, 1, 1));
        vecs.push_back(mk(SUB,  1, 0, 0, 0, PCL,  1, 0, 1));
        vecs.push_back(mk(SUB,  1, 0, 0, 0, PSHF, 1, 0, 1));
        vecs.push_back(mk(SUB,  1, 0, 0, 0, INTJ, 1, 0, 1));
        vecs.push_back(mk(SUB,  1, 0, 0, 1, SUB,  1, 0, 0));
        vecs.push_back(mk(NOP,  0, 0, 0, 1, NOP,  0, 0, 0));
        // Stall blocks the take and keeps int_ack low while INT1 is held
        vecs.push_back(mk(NOP,  0, 0, 1, 1, NOP,  0, 0, 0));
        vecs.push_back(mk(NOP,  0, 1, 0, 0, NOP,  0, 0, 0));
        vecs.push_back(mk(NOP,  0, 0, 0, 0, PCH,  1, 1, 1));
        vecs.push_back(mk(NOP,  0, 1, 0, 0, PCH,  1, 0, 1));
        vecs.push_back(mk(NOP,  0, 0, 0, 0, PCL,  1, 0, 1));
        vecs.push_back(mk(NOP,  0, 0, 0, 0, PSHF, 1, 0, 1));
        vecs.push_back(mk(NOP,  0, 0, 0, 0, INTJ, 1, 0, 1));
        vecs.push_back(mk(NOP,  0, 0, 0, 1, NOP,  0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("v%0d", i));
        end

        // Reset in RET2 with an interrupt pending: abort and lose the request
        apply(mk(RET, 1, 0, 0, 1, PPH, 1, 0, 1), "rst_a");
        apply(mk(NOP, 0, 0, 1, 0, PPL, 1, 0, 1), "rst_b");
        #3;
        rst = 1'b1;
        #1;
        chk("midrst op_out",   op_out,           NOP);
        chk("midrst op_valid", {5'd0, op_valid}, 6'd0);
        chk("midrst seq_busy", {5'd0, seq_busy}, 6'd0);
        chk("midrst in_ready", {5'd0, in_ready}, 6'd0);
        @(negedge clk);
        int_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        apply(mk(ADD, 1, 0, 0, 1, ADD, 1, 0, 0), "post_rst_a");
        apply(mk(NOP, 0, 0, 0, 1, NOP, 0, 0, 0), "post_rst_b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
